// File: rtl/issue_scoreboard.sv
// Decode-stage issue controller: tracks long-latency destination registers, counts in-flight work, serialises CSR/fence/ecall.
// Issue is combinational in the ID cycle (zero latency); stall is asserted whenever ID holds an instruction that cannot move.
module issue_scoreboard #(
  parameter int NREG         = 32,
  parameter int MAX_INFLIGHT = 7,
  parameter int CNT_W        = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             id_valid,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_rs1_used,
  input  logic             id_rs2_used,
  input  logic [4:0]       id_rd,
  input  logic             id_rd_write,
  input  logic             id_long_lat,
  input  logic             id_serialize,
  input  logic             ex_ready,
  input  logic             wb_valid,
  input  logic [4:0]       wb_rd,
  input  logic             wb_long_clear,
  input  logic             flush,
  output logic             issue,
  output logic             stall,
  output logic [NREG-1:0]  pending,
  output logic [CNT_W-1:0] inflight
);

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_DRAIN  = 2'd1,
    ST_SERIAL = 2'd2
  } state_t;

  state_t           state;
  logic             wb_clr;
  logic             raw1;
  logic             raw2;
  logic             waw;
  logic             hazard;
  logic             full;
  logic             empty_ok;
  logic             issue_c;
  logic             retire;
  logic             set_en;
  logic [CNT_W:0]   cnt_sum;
  logic [NREG-1:0]  pending_nxt;

  // A pending bit being cleared by this cycle's writeback is covered by WB forwarding.
  assign wb_clr = wb_valid & wb_long_clear & ~flush;

  assign raw1 = id_rs1_used && (id_rs1 != 5'd0) && pending[id_rs1] &&
                !(wb_clr && (wb_rd == id_rs1));
  assign raw2 = id_rs2_used && (id_rs2 != 5'd0) && pending[id_rs2] &&
                !(wb_clr && (wb_rd == id_rs2));
  assign waw  = id_rd_write && (id_rd != 5'd0) && pending[id_rd] &&
                !(wb_clr && (wb_rd == id_rd));

  assign hazard   = raw1 | raw2 | waw;
  assign full     = (inflight == CNT_W'(MAX_INFLIGHT)) & ~wb_valid;
  assign empty_ok = (inflight == '0) & ex_ready & ~hazard;

  always_comb begin
    issue_c = 1'b0;
    if (!flush && id_valid) begin
      case (state)
        ST_RUN:    issue_c = id_serialize ? empty_ok : (ex_ready & ~hazard & ~full);
        ST_DRAIN:  issue_c = empty_ok;
        default:   issue_c = 1'b0;
      endcase
    end
  end

  assign issue = rst_n & issue_c;
  assign stall = rst_n & id_valid & ~issue_c;

  // A retire with nothing in flight is a protocol error; the count holds at zero.
  assign retire  = wb_valid & (inflight != '0);
  assign cnt_sum = {1'b0, inflight} + {{CNT_W{1'b0}}, issue_c} - {{CNT_W{1'b0}}, retire};

  assign set_en = issue_c & id_long_lat & id_rd_write & (id_rd != 5'd0);

  // Set is applied after clear so a same-register set/clear leaves the bit set.
  always_comb begin
    pending_nxt = pending;
    for (int i = 1; i < NREG; i++) begin
      if (wb_clr && (wb_rd == 5'(i)))
        pending_nxt[i] = 1'b0;
      if (set_en && (id_rd == 5'(i)))
        pending_nxt[i] = 1'b1;
    end
    pending_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_RUN;
      pending  <= '0;
      inflight <= '0;
    end else if (flush) begin
      state    <= ST_RUN;
      pending  <= '0;
      inflight <= '0;
    end else begin
      pending  <= pending_nxt;
      inflight <= cnt_sum[CNT_W-1:0];
      case (state)
        ST_RUN: begin
          if (id_valid && id_serialize)
            state <= issue_c ? ST_SERIAL : ST_DRAIN;
        end
        ST_DRAIN: begin
          if (issue_c)
            state <= ST_SERIAL;
        end
        ST_SERIAL: begin
          if (wb_valid && (inflight == CNT_W'(1)))
            state <= ST_RUN;
        end
        default: state <= ST_RUN;
      endcase
    end
  end

  wb_underflow_a: assert property (@(posedge clk) disable iff (!rst_n)
    !(wb_valid && !flush && (inflight == '0)));

endmodule

// File: tb/tb_issue_scoreboard.sv
// Directed bench for issue_scoreboard: hazard stalls, in-flight limit, serialisation, flush and async reset.
module tb_issue_scoreboard;

  logic        clk;
  logic        rst_n;
  logic        id_valid;
  logic [4:0]  id_rs1;
  logic [4:0]  id_rs2;
  logic        id_rs1_used;
  logic        id_rs2_used;
  logic [4:0]  id_rd;
  logic        id_rd_write;
  logic        id_long_lat;
  logic        id_serialize;
  logic        ex_ready;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic        wb_long_clear;
  logic        flush;
  logic        issue;
  logic        stall;
  logic [31:0] pending;
  logic [2:0]  inflight;

  int n_cmp = 0;
  int n_err = 0;

  issue_scoreboard #(.NREG(32), .MAX_INFLIGHT(7), .CNT_W(3)) dut (
    .clk(clk), .rst_n(rst_n),
    .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
    .id_rd(id_rd), .id_rd_write(id_rd_write), .id_long_lat(id_long_lat),
    .id_serialize(id_serialize), .ex_ready(ex_ready),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_long_clear(wb_long_clear),
    .flush(flush), .issue(issue), .stall(stall),
    .pending(pending), .inflight(inflight)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic instr(input logic v, input logic [4:0] rs1, input logic u1,
                       input logic [4:0] rs2, input logic u2, input logic [4:0] rd,
                       input logic w, input logic ll, input logic ser);
    id_valid = v; id_rs1 = rs1; id_rs1_used = u1; id_rs2 = rs2; id_rs2_used = u2;
    id_rd = rd; id_rd_write = w; id_long_lat = ll; id_serialize = ser;
  endtask

  task automatic wb(input logic v, input logic [4:0] rd, input logic clr);
    wb_valid = v; wb_rd = rd; wb_long_clear = clr;
  endtask

  task automatic idle();
    instr(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    wb(1'b0, 5'd0, 1'b0);
    ex_ready = 1'b1;
    flush    = 1'b0;
  endtask

  // Combinational outputs checked at the falling edge, state checked 1 unit after the rising edge.
  task automatic step(input string tag, input logic exp_issue, input logic exp_stall,
                      input logic [31:0] exp_pend, input logic [2:0] exp_cnt);
    @(negedge clk);
    chk({tag, ".issue"}, {31'd0, issue}, {31'd0, exp_issue});
    chk({tag, ".stall"}, {31'd0, stall}, {31'd0, exp_stall});
    @(posedge clk);
    #1;
    chk({tag, ".pending"}, pending, exp_pend);
    chk({tag, ".inflight"}, {29'd0, inflight}, {29'd0, exp_cnt});
  endtask

  initial begin
    idle();
    rst_n = 1'b0;
    // Valid instruction during reset must neither issue nor stall.
    instr(1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 5'd3, 1'b1, 1'b0, 1'b0);
    #3;
    chk("rst.issue", {31'd0, issue}, 32'd0);
    chk("rst.stall", {31'd0, stall}, 32'd0);
    chk("rst.pending", pending, 32'd0);
    chk("rst.inflight", {29'd0, inflight}, 32'd0);
    idle();
    #9 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Load to x5, dependent read of x5 stalls until its writeback.
    instr(1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 5'd5, 1'b1, 1'b1, 1'b0);
    step("ld_x5", 1'b1, 1'b0, 32'h0000_0020, 3'd1);
    instr(1'b1, 5'd5, 1'b1, 5'd0, 1'b0, 5'd6, 1'b1, 1'b0, 1'b0);
    step("raw_x5_a", 1'b0, 1'b1, 32'h0000_0020, 3'd1);
    step("raw_x5_b", 1'b0, 1'b1, 32'h0000_0020, 3'd1);
    wb(1'b1, 5'd5, 1'b1);
    step("raw_x5_wb", 1'b1, 1'b0, 32'h0000_0000, 3'd1);
    idle();
    wb(1'b1, 5'd6, 1'b0);
    step("ret_x6", 1'b0, 1'b0, 32'h0000_0000, 3'd0);

    // Long-latency write to x0 never marks it pending.
    idle();
    instr(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 1'b1, 1'b0);
    step("ld_x0", 1'b1, 1'b0, 32'h0000_0000, 3'd1);
    instr(1'b1, 5'd0, 1'b1, 5'd0, 1'b0, 5'd7, 1'b1, 1'b0, 1'b0);
    wb(1'b1, 5'd0, 1'b1);
    step("rd_x0", 1'b1, 1'b0, 32'h0000_0000, 3'd1);
    idle();
    wb(1'b1, 5'd7, 1'b0);
    step("ret_x7", 1'b0, 1'b0, 32'h0000_0000, 3'd0);

    // Fill to MAX_INFLIGHT; the 8th waits for a retire.
    idle();
    for (int i = 0; i < 7; i++) begin
      instr(1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 5'd10, 1'b1, 1'b0, 1'b0);
      step("fill", 1'b1, 1'b0, 32'h0000_0000, 3'(i + 1));
    end
    step("full_stall", 1'b0, 1'b1, 32'h0000_0000, 3'd7);
    wb(1'b1, 5'd10, 1'b0);
    step("full_wb", 1'b1, 1'b0, 32'h0000_0000, 3'd7);
    idle();
    wb(1'b1, 5'd10, 1'b0);
    for (int i = 0; i < 4; i++)
      step("drain4", 1'b0, 1'b0, 32'h0000_0000, 3'(6 - i));

    // CSR with 3 in flight: drain, issue into empty back end, then serialise.
    idle();
    instr(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd11, 1'b1, 1'b0, 1'b1);
    step("csr_arrive", 1'b0, 1'b1, 32'h0000_0000, 3'd3);
    wb(1'b1, 5'd10, 1'b0);
    step("csr_drain2", 1'b0, 1'b1, 32'h0000_0000, 3'd2);
    step("csr_drain1", 1'b0, 1'b1, 32'h0000_0000, 3'd1);
    step("csr_drain0", 1'b0, 1'b1, 32'h0000_0000, 3'd0);
    wb(1'b0, 5'd0, 1'b0);
    ex_ready = 1'b0;
    step("csr_exbusy", 1'b0, 1'b1, 32'h0000_0000, 3'd0);
    ex_ready = 1'b1;
    step("csr_issue", 1'b1, 1'b0, 32'h0000_0000, 3'd1);
    instr(1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 5'd12, 1'b1, 1'b0, 1'b0);
    step("serial_a", 1'b0, 1'b1, 32'h0000_0000, 3'd1);
    step("serial_b", 1'b0, 1'b1, 32'h0000_0000, 3'd1);
    wb(1'b1, 5'd11, 1'b0);
    step("serial_wb", 1'b0, 1'b1, 32'h0000_0000, 3'd0);
    wb(1'b0, 5'd0, 1'b0);
    step("serial_exit", 1'b1, 1'b0, 32'h0000_0000, 3'd1);
    idle();
    wb(1'b1, 5'd12, 1'b0);
    step("ret_alu", 1'b0, 1'b0, 32'h0000_0000, 3'd0);

    // Flush during DRAIN with pending[9] set and a simultaneous writeback.
    idle();
    instr(1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 5'd9, 1'b1, 1'b1, 1'b0);
    step("ld_x9", 1'b1, 1'b0, 32'h0000_0200, 3'd1);
    instr(1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 5'd12, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++)
      step("alu3", 1'b1, 1'b0, 32'h0000_0200, 3'(i + 2));
    instr(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1);
    step("fl_drain", 1'b0, 1'b1, 32'h0000_0200, 3'd4);
    flush = 1'b1;
    wb(1'b1, 5'd9, 1'b1);
    step("flush", 1'b0, 1'b1, 32'h0000_0000, 3'd0);
    idle();
    instr(1'b1, 5'd9, 1'b1, 5'd0, 1'b0, 5'd13, 1'b1, 1'b0, 1'b0);
    step("post_fl_a", 1'b1, 1'b0, 32'h0000_0000, 3'd1);
    step("post_fl_b", 1'b1, 1'b0, 32'h0000_0000, 3'd2);
    idle();
    wb(1'b1, 5'd13, 1'b0);
    step("ret_fl_a", 1'b0, 1'b0, 32'h0000_0000, 3'd1);
    step("ret_fl_b", 1'b0, 1'b0, 32'h0000_0000, 3'd0);

    // Async reset while serialising a long-latency CSR.
    idle();
    instr(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd14, 1'b1, 1'b1, 1'b1);
    step("csr_ll", 1'b1, 1'b0, 32'h0000_4000, 3'd1);
    instr(1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 5'd15, 1'b1, 1'b0, 1'b0);
    step("pre_rst", 1'b0, 1'b1, 32'h0000_4000, 3'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst.issue", {31'd0, issue}, 32'd0);
    chk("arst.stall", {31'd0, stall}, 32'd0);
    chk("arst.pending", pending, 32'd0);
    chk("arst.inflight", {29'd0, inflight}, 32'd0);
    idle();
    #3 rst_n = 1'b1;
    @(posedge clk);
    #1;
    instr(1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 5'd15, 1'b1, 1'b0, 1'b0);
    step("post_rst_a", 1'b1, 1'b0, 32'h0000_0000, 3'd1);
    step("post_rst_b", 1'b1, 1'b0, 32'h0000_0000, 3'd2);
    idle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
